// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for a MIPS-style datapath: sequences each instruction,
// drives the ALU and datapath enables, flags illegal opcodes and counts retired instructions.
module multicycle_control #(
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   zero,
    output logic                   pc_en,
    output logic                   iord,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   reg_write,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [2:0]             alu_control,
    output logic [1:0]             pc_source,
    output logic [3:0]             state,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StAluWb    = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StAddiExec = 4'd10,
        StAddiWb   = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnSlt = 6'b101010;

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b011;
    localparam logic [2:0] AluSlt = 3'b100;

    state_e                 state_q, state_d;
    logic                   illegal_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [5:0]             funct_q;
    logic                   illegal_set;
    logic                   retire;
    logic                   funct_ok;

    assign funct_ok = (funct == FnAnd) || (funct == FnOr) || (funct == FnAdd) ||
                      (funct == FnSub) || (funct == FnSlt);

    always_comb begin
        state_d     = StFetch;
        illegal_set = 1'b0;
        retire      = 1'b0;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpRtype: begin
                        if (funct_ok) state_d = StExecute;
                        else          illegal_set = 1'b1;
                    end
                    OpLw, OpSw: state_d = StMemAddr;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiExec;
                    default:    illegal_set = 1'b1;
                endcase
            end
            StMemAddr:  state_d = (opcode == OpLw) ? StMemRead : StMemWrite;
            StMemRead:  state_d = StMemWb;
            StExecute:  state_d = StAluWb;
            StAddiExec: state_d = StAddiWb;
            StMemWb, StMemWrite, StAluWb, StBranch, StJump, StAddiWb: retire = 1'b1;
            default:    illegal_set = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
            count_q   <= '0;
            funct_q   <= '0;
        end else begin
            state_q <= state_d;
            if (illegal_set) illegal_q <= 1'b1;
            if (retire)      count_q   <= count_q + COUNT_WIDTH'(1);
            // EXECUTE decodes from this copy so later IR changes cannot disturb it
            if (state_q == StDecode) funct_q <= funct;
        end
    end

    always_comb begin
        pc_en       = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = AluAnd;
        pc_source   = 2'b00;
        if (!reset) begin
            case (state_q)
                StFetch: begin
                    mem_read    = 1'b1;
                    ir_write    = 1'b1;
                    pc_en       = 1'b1;
                    alu_src_b   = 2'b01;
                    alu_control = AluAdd;
                end
                StDecode: begin
                    alu_src_b   = 2'b11;
                    alu_control = AluAdd;
                end
                StMemAddr: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = AluAdd;
                end
                StMemRead: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                StMemWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                StMemWrite: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                StExecute: begin
                    alu_src_a = 1'b1;
                    case (funct_q)
                        FnAnd:   alu_control = AluAnd;
                        FnOr:    alu_control = AluOr;
                        FnAdd:   alu_control = AluAdd;
                        FnSub:   alu_control = AluSub;
                        FnSlt:   alu_control = AluSlt;
                        default: alu_control = AluAnd;
                    endcase
                end
                StAluWb: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                StBranch: begin
                    alu_src_a   = 1'b1;
                    alu_control = AluSub;
                    pc_source   = 2'b01;
                    pc_en       = zero;
                end
                StJump: begin
                    pc_source = 2'b10;
                    pc_en     = 1'b1;
                end
                StAddiExec: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = AluAdd;
                end
                StAddiWb: reg_write = 1'b1;
                default: ;
            endcase
        end
    end

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through its states
// and checks strobes, ALU control, the sticky illegal flag and the retire counter.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode, funct;
    logic        zero;
    logic        pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b, pc_source;
    logic [2:0]  alu_control;
    logic [3:0]  state;
    logic        illegal;
    logic [31:0] instr_count;

    int vectors = 0;
    int miscompares = 0;

    multicycle_control #(.COUNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .pc_source(pc_source), .state(state),
        .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
        tick();
        tick();
        vectors++;
        if (state !== 4'd0) begin
            miscompares++; $display("FAIL reset_state: got %0d want 0", state);
        end
        vectors++;
        if (instr_count !== 32'd0) begin
            miscompares++; $display("FAIL reset_count: got %0d want 0", instr_count);
        end
        vectors++;
        if ({pc_en, iord, mem_read, mem_write, ir_write, reg_write, alu_control} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b want 0",
                     {pc_en, iord, mem_read, mem_write, ir_write, reg_write, alu_control});
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({mem_read, ir_write, pc_en, alu_src_b, alu_control} !== {3'b111, 2'b01, 3'b010}) begin
            miscompares++;
            $display("FAIL fetch_outputs: got %b want 11101010",
                     {mem_read, ir_write, pc_en, alu_src_b, alu_control});
        end
    endtask

    // R-type: 0,1,6,7,0; funct is scrambled after DECODE to prove it was latched
    task automatic test_rtype(input logic [5:0] fn, input logic [2:0] alu_exp,
                              input logic [31:0] cnt_exp);
        opcode = 6'b000000; funct = fn;
        tick();
        vectors++;
        if (state !== 4'd1 || alu_src_b !== 2'b11) begin
            miscompares++; $display("FAIL rtype_decode: got %0d/%b want 1/11", state, alu_src_b);
        end
        tick();
        funct = 6'b111111;
        #1;
        vectors++;
        if (state !== 4'd6 || alu_control !== alu_exp || alu_src_a !== 1'b1) begin
            miscompares++;
            $display("FAIL rtype_exec: got st=%0d alu=%b a=%b want st=6 alu=%b a=1",
                     state, alu_control, alu_src_a, alu_exp);
        end
        tick();
        vectors++;
        if (state !== 4'd7 || reg_write !== 1'b1 || reg_dst !== 1'b1) begin
            miscompares++;
            $display("FAIL rtype_wb: got st=%0d rw=%b rd=%b want 7/1/1", state, reg_write, reg_dst);
        end
        tick();
        vectors++;
        if (state !== 4'd0 || instr_count !== cnt_exp) begin
            miscompares++;
            $display("FAIL rtype_retire: got st=%0d cnt=%0d want 0/%0d", state, instr_count, cnt_exp);
        end
    endtask

    task automatic test_lw_sw();
        opcode = 6'b100011; funct = 6'd0;
        tick();
        tick();
        vectors++;
        if (state !== 4'd2 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_control !== 3'b010) begin
            miscompares++; $display("FAIL lw_addr: got st=%0d b=%b alu=%b", state, alu_src_b, alu_control);
        end
        tick();
        vectors++;
        if (state !== 4'd3 || iord !== 1'b1 || mem_read !== 1'b1) begin
            miscompares++; $display("FAIL lw_read: got st=%0d iord=%b mr=%b want 3/1/1", state, iord, mem_read);
        end
        tick();
        vectors++;
        if (state !== 4'd4 || mem_to_reg !== 1'b1 || reg_write !== 1'b1 || reg_dst !== 1'b0) begin
            miscompares++;
            $display("FAIL lw_wb: got st=%0d m2r=%b rw=%b rd=%b", state, mem_to_reg, reg_write, reg_dst);
        end
        tick();
        vectors++;
        if (state !== 4'd0 || instr_count !== 32'd3) begin
            miscompares++; $display("FAIL lw_retire: got st=%0d cnt=%0d want 0/3", state, instr_count);
        end
        opcode = 6'b101011;
        tick();
        tick();
        tick();
        vectors++;
        if (state !== 4'd5 || mem_write !== 1'b1 || iord !== 1'b1 || mem_read !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_write: got st=%0d mw=%b iord=%b mr=%b", state, mem_write, iord, mem_read);
        end
        tick();
        vectors++;
        if (state !== 4'd0 || instr_count !== 32'd4) begin
            miscompares++; $display("FAIL sw_retire: got st=%0d cnt=%0d want 0/4", state, instr_count);
        end
    endtask

    task automatic test_branch(input logic z, input logic [31:0] cnt_exp);
        opcode = 6'b000100; zero = z;
        tick();
        tick();
        vectors++;
        if (state !== 4'd8 || pc_en !== z || pc_source !== 2'b01 || alu_control !== 3'b011) begin
            miscompares++;
            $display("FAIL beq_z%0d: got st=%0d pcen=%b src=%b alu=%b want 8/%b/01/011",
                     z, state, pc_en, pc_source, alu_control, z);
        end
        tick();
        zero = 1'b0;
        vectors++;
        if (state !== 4'd0 || instr_count !== cnt_exp) begin
            miscompares++;
            $display("FAIL beq_retire: got st=%0d cnt=%0d want 0/%0d", state, instr_count, cnt_exp);
        end
    endtask

    task automatic test_jump();
        opcode = 6'b000010;
        tick();
        tick();
        vectors++;
        if (state !== 4'd9 || pc_en !== 1'b1 || pc_source !== 2'b10) begin
            miscompares++; $display("FAIL jump: got st=%0d pcen=%b src=%b want 9/1/10", state, pc_en, pc_source);
        end
        tick();
        vectors++;
        if (state !== 4'd0 || instr_count !== 32'd7) begin
            miscompares++; $display("FAIL jump_retire: got st=%0d cnt=%0d want 0/7", state, instr_count);
        end
    endtask

    task automatic test_illegal();
        opcode = 6'b111111;
        tick();
        tick();
        vectors++;
        if (state !== 4'd0 || illegal !== 1'b1 || instr_count !== 32'd7) begin
            miscompares++;
            $display("FAIL illegal_op: got st=%0d ill=%b cnt=%0d want 0/1/7", state, illegal, instr_count);
        end
        opcode = 6'b001000;
        tick();
        tick();
        vectors++;
        if (state !== 4'd10 || alu_src_b !== 2'b10 || alu_control !== 3'b010) begin
            miscompares++; $display("FAIL addi_exec: got st=%0d b=%b alu=%b", state, alu_src_b, alu_control);
        end
        tick();
        vectors++;
        if (state !== 4'd11 || reg_write !== 1'b1 || reg_dst !== 1'b0) begin
            miscompares++; $display("FAIL addi_wb: got st=%0d rw=%b rd=%b", state, reg_write, reg_dst);
        end
        tick();
        vectors++;
        if (state !== 4'd0 || illegal !== 1'b1 || instr_count !== 32'd8) begin
            miscompares++;
            $display("FAIL addi_retire: got st=%0d ill=%b cnt=%0d want 0/1/8", state, illegal, instr_count);
        end
    endtask

    task automatic test_reset_mid_lw();
        opcode = 6'b100011;
        tick();
        tick();
        tick();
        vectors++;
        if (state !== 4'd3) begin
            miscompares++; $display("FAIL mid_lw_reach: got st=%0d want 3", state);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (reg_write !== 1'b0 || mem_read !== 1'b0) begin
            miscompares++; $display("FAIL mid_lw_gate: got rw=%b mr=%b want 0/0", reg_write, mem_read);
        end
        tick();
        vectors++;
        if (state !== 4'd0 || instr_count !== 32'd0 || illegal !== 1'b0 || reg_write !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_lw_reset: got st=%0d cnt=%0d ill=%b rw=%b want 0/0/0/0",
                     state, instr_count, illegal, reg_write);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (state !== 4'd0 || reg_write !== 1'b0 || mem_read !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset: got st=%0d rw=%b mr=%b want 0/0/1", state, reg_write, mem_read);
        end
    endtask

    initial begin
        test_reset();
        test_rtype(6'b100100, 3'b000, 32'd1);
        test_rtype(6'b101010, 3'b100, 32'd2);
        test_lw_sw();
        test_branch(1'b1, 32'd5);
        test_branch(1'b0, 32'd6);
        test_jump();
        test_illegal();
        test_reset_mid_lw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
